hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch interlocks,
// multi-cycle mult/div stall sequencing, memory-wait stalls and exception flushes.
module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       startdivE,
  input  logic       exceptionM,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       div_busy,
  output logic       div_done
);

  localparam logic ST_RUN = 1'b0;
  localparam logic ST_DIV = 1'b1;

  logic       r_state;
  logic [5:0] r_cnt;

  logic w_m_valid, w_w_valid, w_e_valid;
  logic w_load_use, w_branch_haz, w_hazard;
  logic w_mem_wait, w_div_start, w_div_stall, w_div_last;

  assign w_m_valid = regwriteM && (writeregM != 5'd0);
  assign w_w_valid = regwriteW && (writeregW != 5'd0);
  assign w_e_valid = writeregE != 5'd0;

  assign w_load_use = memtoregE && w_e_valid && ((writeregE == rsD) || (writeregE == rtD));
  assign w_branch_haz = (branchD || jrD) &&
      ((regwriteE && w_e_valid && ((writeregE == rsD) || (writeregE == rtD))) ||
       (memtoregM && (writeregM != 5'd0) && ((writeregM == rsD) || (writeregM == rtD))));
  assign w_hazard = w_load_use || w_branch_haz;

  assign w_mem_wait  = !imem_ready || !dmem_ready;
  assign w_div_start = (r_state == ST_RUN) && startdivE;
  assign w_div_last  = (r_state == ST_DIV) && (r_cnt == 6'd0);
  assign w_div_stall = w_div_start || ((r_state == ST_DIV) && (r_cnt != 6'd0));

  assign div_busy = (r_state == ST_DIV);
  assign div_done = w_div_last && !reset && !exceptionM;

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (reset || exceptionM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      // A flush is only raised for a stage that no higher-priority source is holding.
      stallF = w_mem_wait || w_div_stall || w_hazard;
      stallD = stallF;
      stallE = w_mem_wait || w_div_stall;
      stallM = w_mem_wait;
      flushW = w_mem_wait;
      flushM = w_div_stall && !w_mem_wait;
      flushE = w_hazard && !w_mem_wait && !w_div_stall;
    end
    if (!reset) begin
      forwardAD = w_m_valid && (writeregM == rsD);
      forwardBD = w_m_valid && (writeregM == rtD);
      if (w_m_valid && (writeregM == rsE))      forwardAE = 2'b10;
      else if (w_w_valid && (writeregW == rsE)) forwardAE = 2'b01;
      if (w_m_valid && (writeregM == rtE))      forwardBE = 2'b10;
      else if (w_w_valid && (writeregW == rtE)) forwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || exceptionM) begin
      r_state <= ST_RUN;
      r_cnt   <= 6'd0;
    end else if (w_div_start) begin
      r_state <= ST_DIV;
      r_cnt   <= 6'(DIV_CYCLES - 1);
    end else if (r_state == ST_DIV) begin
      if (r_cnt == 6'd0) begin
        r_state <= ST_RUN;
      end else begin
        r_cnt <= r_cnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-age reference model.
module tb_hazard_ctrl;
  localparam int DIVC = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, startdivE, exceptionM, imem_ready, dmem_ready;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic       forwardAD, forwardBD, div_busy, div_done;
  logic [1:0] forwardAE, forwardBE;

  int n_cmp = 0;
  int n_err = 0;
  // Model: -1 idle, otherwise cycles elapsed since the start cycle.
  int div_age = -1;
  int cnt_stallE, cnt_done;

  hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .jrD(jrD),
    .startdivE(startdivE), .exceptionM(exceptionM), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    reset = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; jrD = 0; startdivE = 0; exceptionM = 0; imem_ready = 1; dmem_ready = 1;
  endtask

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (regwriteM && writeregM != 0 && writeregM == r) return 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == r) return 2'b01;
    return 2'b00;
  endfunction

  // Check every output for the inputs currently applied, then advance the model a cycle.
  task automatic step();
    int  age;
    bit  lu, br, haz, mem, dst, dn;
    bit  e_sf, e_se, e_sm, e_fd, e_fe, e_fm, e_fw;
    #1;
    age = (div_age < 0 && startdivE) ? 0 : div_age;
    dst = (age >= 0) && (age < DIVC);
    dn  = (age == DIVC) && !reset && !exceptionM;
    lu  = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    br  = (branchD || jrD) &&
          ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
           (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
    haz = lu || br;
    mem = !imem_ready || !dmem_ready;
    if (reset || exceptionM) begin
      {e_sf, e_se, e_sm} = 3'b000;
      {e_fd, e_fe, e_fm, e_fw} = 4'b1111;
    end else begin
      e_sf = mem || dst || haz;
      e_se = mem || dst;
      e_sm = mem;
      e_fd = 0;
      e_fw = mem;
      e_fm = dst && !mem;
      e_fe = haz && !mem && !dst;
    end
    check_eq("stallF", 8'(stallF), 8'(e_sf));
    check_eq("stallD", 8'(stallD), 8'(e_sf));
    check_eq("stallE", 8'(stallE), 8'(e_se));
    check_eq("stallM", 8'(stallM), 8'(e_sm));
    check_eq("flushD", 8'(flushD), 8'(e_fd));
    check_eq("flushE", 8'(flushE), 8'(e_fe));
    check_eq("flushM", 8'(flushM), 8'(e_fm));
    check_eq("flushW", 8'(flushW), 8'(e_fw));
    check_eq("forwardAE", 8'(forwardAE), reset ? 8'd0 : 8'(fwd_e(rsE)));
    check_eq("forwardBE", 8'(forwardBE), reset ? 8'd0 : 8'(fwd_e(rtE)));
    check_eq("forwardAD", 8'(forwardAD),
             8'(!reset && regwriteM && writeregM != 0 && writeregM == rsD));
    check_eq("forwardBD", 8'(forwardBD),
             8'(!reset && regwriteM && writeregM != 0 && writeregM == rtD));
    check_eq("div_busy", 8'(div_busy), 8'(div_age >= 1));
    check_eq("div_done", 8'(div_done), 8'(dn));
    cnt_stallE += int'(stallE);
    cnt_done   += int'(div_done);
    if (reset || exceptionM || age < 0 || age == DIVC) div_age = -1;
    else div_age = age + 1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    @(negedge clk);
    #1;
    step();
    step();
    clear_in();

    // Load-use on $8, then the consumer reaches E with the load in M.
    memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
    step();
    clear_in();
    memtoregM = 1; regwriteM = 1; writeregM = 8; rsE = 8;
    step();
    check_eq("lu_fwdAE", 8'(forwardAE), 8'h2);

    // Branch hazard on $9; then $0 never interlocks.
    clear_in(); branchD = 1; rsD = 9; regwriteE = 1; writeregE = 9;
    step();
    clear_in(); branchD = 1; rsD = 0; regwriteE = 1; writeregE = 0; regwriteM = 1;
    step();
    check_eq("r0_stallF", 8'(stallF), 8'd0);

    // Full divide: stall count and single done pulse.
    clear_in(); cnt_stallE = 0; cnt_done = 0; startdivE = 1;
    step();
    startdivE = 0;
    for (int i = 0; i < DIVC + 4; i++) step();
    check_eq("div_stall_cycles", 8'(cnt_stallE), 8'(DIVC));
    check_eq("div_done_pulses", 8'(cnt_done), 8'd1);

    // Exception mid-divide suppresses done.
    cnt_done = 0; startdivE = 1;
    step();
    startdivE = 0;
    for (int i = 0; i < DIVC - 11; i++) step();
    exceptionM = 1;
    step();
    exceptionM = 0;
    for (int i = 0; i < DIVC; i++) step();
    check_eq("exc_no_done", 8'(cnt_done), 8'd0);

    // Memory wait overlapping a load-use hazard.
    clear_in(); memtoregE = 1; writeregE = 5; rtD = 5; dmem_ready = 0;
    for (int i = 0; i < 3; i++) step();
    dmem_ready = 1;
    step();

    // Reset mid-divide, then a clean restart.
    clear_in(); cnt_done = 0; startdivE = 1;
    step();
    startdivE = 0;
    for (int i = 0; i < 7; i++) step();
    reset = 1;
    step();
    reset = 0;
    cnt_stallE = 0; startdivE = 1;
    step();
    startdivE = 0;
    for (int i = 0; i < DIVC + 3; i++) step();
    check_eq("rst_restart_stalls", 8'(cnt_stallE), 8'(DIVC));
    check_eq("rst_restart_done", 8'(cnt_done), 8'd1);

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 4000; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = 1'($urandom); memtoregM = 1'($urandom);
      branchD = ($urandom_range(0, 3) == 0); jrD = ($urandom_range(0, 7) == 0);
      startdivE = ($urandom_range(0, 15) == 0);
      exceptionM = ($urandom_range(0, 99) == 0);
      imem_ready = ($urandom_range(0, 9) != 0);
      dmem_ready = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
